// File: rtl/gorev_besleyici.sv
// Initiator for the gorev_birimi pixel stream: takes a task command, raster-reads one frame
// from a 1-cycle-latency memory, streams it out and counts the returned result pulses.
module gorev_besleyici #(
    parameter int PIXEL_BIT   = 8,
    parameter int GRV_BIT     = 3,
    parameter int GENISLIK    = 320,
    parameter int YUKSEKLIK   = 240,
    parameter int ADR_BIT     = 17,
    parameter int ZAMAN_ASIMI = 1024
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 komut_gecerli_i,
    input  logic [GRV_BIT-1:0]   komut_gorev_i,
    output logic                 komut_hazir_o,
    output logic                 basla_o,
    output logic [GRV_BIT-1:0]   gorev_o,
    output logic                 okuma_istek_o,
    output logic [ADR_BIT-1:0]   okuma_adres_o,
    input  logic [PIXEL_BIT-1:0] okuma_veri_i,
    input  logic                 durdur_i,
    output logic                 etkin_o,
    output logic [PIXEL_BIT-1:0] pixel_o,
    input  logic                 sonuc_etkin_i,
    output logic [ADR_BIT:0]     sonuc_sayac_o,
    output logic                 mesgul_o,
    output logic                 bitti_o,
    output logic                 hata_o
);

    localparam int N      = GENISLIK * YUKSEKLIK;
    localparam int ZA_BIT = $clog2(ZAMAN_ASIMI + 1);

    localparam logic [ADR_BIT-1:0] SON_ADR = ADR_BIT'(N - 1);
    localparam logic [ADR_BIT:0]   TOPLAM  = (ADR_BIT + 1)'(N);
    localparam logic [ZA_BIT-1:0]  ZA_SON  = ZA_BIT'(ZAMAN_ASIMI - 1);

    typedef enum logic [2:0] {
        BOSTA,
        BASLA,
        AKIS,
        BOSALT,
        BITTI
    } durum_t;

    durum_t              durum;
    durum_t              sonraki;
    logic [ADR_BIT-1:0]  adres;
    logic [ADR_BIT:0]    sayac;
    logic [ZA_BIT-1:0]   zaman;
    logic                istek_d;
    logic                hata;
    logic                kabul;
    logic                istek;
    logic                sayac_aktif;
    logic                bosaldi;
    logic                tamam;
    logic                zaman_doldu;

    assign kabul       = (durum == BOSTA) && komut_gecerli_i;
    assign istek       = (durum == AKIS) && !durdur_i;
    assign sayac_aktif = (durum == BASLA) || (durum == AKIS) || (durum == BOSALT);
    // Drained once no read is waiting for data and the last pixel has left the output register
    assign bosaldi     = !istek_d && !etkin_o;
    assign tamam       = bosaldi && (sayac == TOPLAM);
    assign zaman_doldu = !sonuc_etkin_i && (zaman == ZA_SON);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            durum <= BOSTA;
        end else begin
            durum <= sonraki;
        end
    end

    always_comb begin
        sonraki = durum;
        case (durum)
            BOSTA:   if (kabul) sonraki = BASLA;
            BASLA:   sonraki = AKIS;
            AKIS:    if (istek && (adres == SON_ADR)) sonraki = BOSALT;
            BOSALT:  if (tamam || zaman_doldu) sonraki = BITTI;
            BITTI:   sonraki = BOSTA;
            default: sonraki = BOSTA;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            gorev_o <= '0;
            adres   <= '0;
            sayac   <= '0;
            zaman   <= '0;
            hata    <= 1'b0;
        end else begin
            if (kabul) begin
                gorev_o <= komut_gorev_i;
                adres   <= '0;
            end else if (istek && (adres != SON_ADR)) begin
                adres <= adres + 1'b1;
            end

            if (kabul) begin
                sayac <= '0;
            end else if (sayac_aktif && sonuc_etkin_i && (sayac != TOPLAM)) begin
                sayac <= sayac + 1'b1;
            end

            // Idle-cycle counter only runs in BOSALT; any result pulse restarts the window
            if ((durum != BOSALT) || sonuc_etkin_i) begin
                zaman <= '0;
            end else begin
                zaman <= zaman + 1'b1;
            end

            if (kabul) begin
                hata <= 1'b0;
            end else if ((durum == BOSALT) && !tamam && zaman_doldu) begin
                hata <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            istek_d <= 1'b0;
            etkin_o <= 1'b0;
            pixel_o <= '0;
        end else begin
            istek_d <= istek;
            etkin_o <= istek_d;
            if (istek_d) begin
                pixel_o <= okuma_veri_i;
            end
        end
    end

    assign komut_hazir_o = (durum == BOSTA);
    assign basla_o       = (durum == BASLA);
    assign mesgul_o      = (durum != BOSTA);
    assign bitti_o       = (durum == BITTI);
    assign okuma_istek_o = istek;
    assign okuma_adres_o = adres;
    assign sonuc_sayac_o = sayac;
    assign hata_o        = hata;

endmodule

// File: tb/tb_gorev_besleyici.sv
// Directed bench for gorev_besleyici on a 4x2 frame; memory returns its own address and
// result pulses loop back from etkin_o, optionally cut off after a given number of pulses.
module tb_gorev_besleyici;

    localparam int PIXEL_BIT   = 8;
    localparam int GRV_BIT     = 3;
    localparam int GENISLIK    = 4;
    localparam int YUKSEKLIK   = 2;
    localparam int ADR_BIT     = 17;
    localparam int ZAMAN_ASIMI = 8;

    logic                 clk = 1'b0;
    logic                 rstn = 1'b0;
    logic                 komut_gecerli = 1'b0;
    logic [GRV_BIT-1:0]   komut_gorev = '0;
    logic                 komut_hazir;
    logic                 basla;
    logic [GRV_BIT-1:0]   gorev;
    logic                 okuma_istek;
    logic [ADR_BIT-1:0]   okuma_adres;
    logic [PIXEL_BIT-1:0] okuma_veri = '0;
    logic                 durdur = 1'b0;
    logic                 etkin;
    logic [PIXEL_BIT-1:0] pixel;
    logic                 sonuc_etkin;
    logic [ADR_BIT:0]     sonuc_sayac;
    logic                 mesgul;
    logic                 bitti;
    logic                 hata;

    int tests_run = 0;
    int tests_failed = 0;
    int sonuc_verilen = 0;
    int sonuc_taban = 0;
    int sonuc_limit = 100;

    int basla_k[$];
    int istek_k[$];
    int istek_a[$];
    int etkin_k[$];
    int pixel_v[$];
    int bitti_k, bitti_hata, bitti_sayac, bitti_pixel, bitti_adr;
    int k0_hata, k1_sayac, k1_hata, k1_mesgul, busy_hazir;

    gorev_besleyici #(
        .PIXEL_BIT(PIXEL_BIT), .GRV_BIT(GRV_BIT), .GENISLIK(GENISLIK),
        .YUKSEKLIK(YUKSEKLIK), .ADR_BIT(ADR_BIT), .ZAMAN_ASIMI(ZAMAN_ASIMI)
    ) dut (
        .clk_i(clk), .rstn_i(rstn),
        .komut_gecerli_i(komut_gecerli), .komut_gorev_i(komut_gorev), .komut_hazir_o(komut_hazir),
        .basla_o(basla), .gorev_o(gorev),
        .okuma_istek_o(okuma_istek), .okuma_adres_o(okuma_adres), .okuma_veri_i(okuma_veri),
        .durdur_i(durdur), .etkin_o(etkin), .pixel_o(pixel),
        .sonuc_etkin_i(sonuc_etkin), .sonuc_sayac_o(sonuc_sayac),
        .mesgul_o(mesgul), .bitti_o(bitti), .hata_o(hata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (okuma_istek) okuma_veri <= okuma_adres[PIXEL_BIT-1:0];
    end

    always @(posedge clk) begin
        if (sonuc_etkin) sonuc_verilen <= sonuc_verilen + 1;
    end

    assign sonuc_etkin = etkin && ((sonuc_verilen - sonuc_taban) < sonuc_limit);

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Cycle 0 is the command cycle; everything is logged as an offset k from it
    task automatic applyStimulus(input int g, input int ds, input int dl, input int lim,
                                 input int busy_k, input int busy_g);
        basla_k.delete(); istek_k.delete(); istek_a.delete(); etkin_k.delete(); pixel_v.delete();
        bitti_k = -1; busy_hazir = -1;
        @(posedge clk); #1;
        sonuc_taban   = sonuc_verilen;
        sonuc_limit   = lim;
        komut_gecerli = 1'b1;
        komut_gorev   = GRV_BIT'(g);
        durdur        = 1'b0;
        #2;
        k0_hata = int'(hata);
        checkOutput("hazir_kabul", komut_hazir, 1);
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            komut_gecerli = (k == busy_k);
            komut_gorev   = (k == busy_k) ? GRV_BIT'(busy_g) : GRV_BIT'(g);
            durdur        = (k >= ds) && (k < ds + dl);
            #2;
            if (k == busy_k) busy_hazir = int'(komut_hazir);
            if (k == 1) begin
                k1_sayac = int'(sonuc_sayac); k1_hata = int'(hata); k1_mesgul = int'(mesgul);
            end
            if (basla) basla_k.push_back(k);
            if (okuma_istek) begin istek_k.push_back(k); istek_a.push_back(int'(okuma_adres)); end
            if (etkin) begin etkin_k.push_back(k); pixel_v.push_back(int'(pixel)); end
            if (bitti) begin
                bitti_k = k; bitti_hata = int'(hata); bitti_sayac = int'(sonuc_sayac);
                bitti_pixel = int'(pixel); bitti_adr = int'(okuma_adres);
                break;
            end
        end
        komut_gecerli = 1'b0;
        durdur = 1'b0;
        if (bitti_k < 0) checkOutput("bitti_sure", 0, 1);
    endtask

    // Reads and pixels follow command+2 / command+4, shifted by the stall length from stall_at on
    task automatic checkAkis(input string ad, input int stall_at, input int stall_len);
        checkOutput({ad, "_istek_n"}, istek_k.size(), 8);
        checkOutput({ad, "_etkin_n"}, etkin_k.size(), 8);
        for (int i = 0; i < 8 && i < istek_k.size(); i++) begin
            int gec;
            gec = (i >= stall_at) ? stall_len : 0;
            checkOutput({ad, "_istek_k"}, istek_k[i], 2 + i + gec);
            checkOutput({ad, "_istek_adr"}, istek_a[i], i);
        end
        for (int i = 0; i < 8 && i < etkin_k.size(); i++) begin
            int gec;
            gec = (i >= stall_at) ? stall_len : 0;
            checkOutput({ad, "_etkin_k"}, etkin_k[i], 4 + i + gec);
            checkOutput({ad, "_pixel"}, pixel_v[i], i);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_hazir", komut_hazir, 1);
        checkOutput("rst_mesgul", mesgul, 0);
        checkOutput("rst_basla", basla, 0);
        checkOutput("rst_istek", okuma_istek, 0);
        checkOutput("rst_etkin", etkin, 0);
        checkOutput("rst_bitti", bitti, 0);
        checkOutput("rst_hata", hata, 0);
        checkOutput("rst_sayac", sonuc_sayac, 0);
        checkOutput("rst_gorev", gorev, 0);
        rstn = 1'b1;

        // T1: reset in the middle of streaming
        @(posedge clk); #1;
        komut_gecerli = 1'b1; komut_gorev = 3'd2;
        @(posedge clk); #1;
        komut_gecerli = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("t1_istek_once", okuma_istek, 1);
        checkOutput("t1_etkin_once", etkin, 1);
        rstn = 1'b0;
        #1;
        checkOutput("t1_hazir", komut_hazir, 1);
        checkOutput("t1_istek", okuma_istek, 0);
        checkOutput("t1_mesgul", mesgul, 0);
        checkOutput("t1_etkin", etkin, 0);
        checkOutput("t1_gorev", gorev, 0);
        checkOutput("t1_adres", okuma_adres, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checkOutput("t1_istek_tut", okuma_istek, 0);
            checkOutput("t1_bitti_tut", bitti, 0);
        end
        rstn = 1'b1;

        // T2: plain frame with full loopback
        applyStimulus(3, 0, 0, 100, 0, 0);
        checkOutput("t2_basla_n", basla_k.size(), 1);
        if (basla_k.size() > 0) checkOutput("t2_basla_k", basla_k[0], 1);
        checkOutput("t2_mesgul", k1_mesgul, 1);
        checkAkis("t2", 8, 0);
        checkOutput("t2_bitti_k", bitti_k, 13);
        checkOutput("t2_hata", bitti_hata, 0);
        checkOutput("t2_sayac", bitti_sayac, 8);
        checkOutput("t2_pixel_tut", bitti_pixel, 7);
        checkOutput("t2_adr_son", bitti_adr, 7);
        checkOutput("t2_gorev", gorev, 3);

        // T3: three-cycle stall right after address 2
        applyStimulus(4, 5, 3, 100, 0, 0);
        checkAkis("t3", 3, 3);
        checkOutput("t3_bitti_k", bitti_k, 16);
        checkOutput("t3_sayac", bitti_sayac, 8);

        // T5: command while busy is dropped
        applyStimulus(3, 0, 0, 100, 5, 5);
        checkOutput("t5_hazir", busy_hazir, 0);
        checkOutput("t5_basla_n", basla_k.size(), 1);
        checkOutput("t5_bitti_k", bitti_k, 13);
        checkOutput("t5_gorev", gorev, 3);

        // T4: only 5 results; BOSALT entered at k=10 tolerates 8 idle cycles
        applyStimulus(1, 0, 0, 5, 0, 0);
        checkAkis("t4", 8, 0);
        checkOutput("t4_bitti_k", bitti_k, 18);
        checkOutput("t4_hata", bitti_hata, 1);
        checkOutput("t4_sayac", bitti_sayac, 5);

        // T6: next command in the first ready cycle after bitti
        applyStimulus(6, 0, 0, 100, 0, 0);
        checkOutput("t6_hata_tut", k0_hata, 1);
        checkOutput("t6_basla_n", basla_k.size(), 1);
        if (basla_k.size() > 0) checkOutput("t6_basla_k", basla_k[0], 1);
        checkOutput("t6_sayac_sifir", k1_sayac, 0);
        checkOutput("t6_hata_sifir", k1_hata, 0);
        checkOutput("t6_bitti_k", bitti_k, 13);
        checkOutput("t6_sayac", bitti_sayac, 8);
        checkOutput("t6_hata", bitti_hata, 0);
        checkOutput("t6_gorev", gorev, 6);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
